// File: rtl/input_periph.sv
`default_nettype none
// ============================================================================
// Module   : input_periph
// Summary  : Memory-mapped load-path peripheral: synchronized switches,
//            debounced push-buttons with sticky press capture (W1C).
//            Optional mask register and interrupt under INPUT_PERIPH_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_periph #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          SW_W            = 18,
  parameter int          KEY_W           = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [SW_W-1:0]   sw,
  input  logic [KEY_W-1:0]  key,
  input  logic              ld_en,
  input  logic              st_en,
  input  logic [7:0]        addr,
  input  logic [31:0]       st_data,
  output logic [31:0]       ld_data
`ifdef INPUT_PERIPH_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  localparam logic [7:0]  c_addr_sw   = 8'h00;
  localparam logic [7:0]  c_addr_key  = 8'h10;
  localparam logic [7:0]  c_addr_edge = 8'h20;
  localparam logic [15:0] c_cnt_last  = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [15:0] c_cnt_max   = 16'hFFFF;

  logic [SW_W-1:0]  r_sw_s1, r_sw_s2;
  logic [KEY_W-1:0] r_key_s1, r_key_s2;
  logic [KEY_W-1:0] r_stable;
  logic [15:0]      r_cnt [KEY_W];
  logic [KEY_W-1:0] r_edge;
  logic [31:0]      r_ld_data;

  logic [KEY_W-1:0] w_stable_nxt;
  logic [15:0]      w_cnt_nxt [KEY_W];
  logic [KEY_W-1:0] w_rise;
  logic [KEY_W-1:0] w_edge_clr;
  logic [31:0]      w_rd_data;
  logic             w_unused_ok;

  assign w_unused_ok = &{1'b0, st_data[31:KEY_W]};

  // Two-stage synchronizers; keys are inverted so 1 means pressed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_key_s1 <= '0;
      r_key_s2 <= '0;
    end else begin
      r_sw_s1  <= sw;
      r_sw_s2  <= r_sw_s1;
      r_key_s1 <= ~key;
      r_key_s2 <= r_key_s1;
    end
  end

  // Stable level flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < KEY_W; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_key_s2[i] != r_stable[i]) begin
        if (r_cnt[i] == c_cnt_last) begin
          w_stable_nxt[i] = r_key_s2[i];
        end else if (r_cnt[i] != c_cnt_max) begin
          w_cnt_nxt[i] = r_cnt[i] + 16'd1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i];
        end
      end
    end
  end

  assign w_rise     = w_stable_nxt & ~r_stable;
  assign w_edge_clr = (st_en && (addr == c_addr_edge)) ? st_data[KEY_W-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stable <= '0;
      r_edge   <= '0;
      for (int i = 0; i < KEY_W; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_nxt;
      // A press in the same cycle as a clear keeps the bit set.
      r_edge   <= (r_edge & ~w_edge_clr) | w_rise;
      for (int i = 0; i < KEY_W; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

`ifdef INPUT_PERIPH_IRQ_EN
  localparam logic [7:0] c_addr_mask = 8'h30;

  logic [KEY_W-1:0] r_mask;
  logic             r_irq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (st_en && (addr == c_addr_mask)) begin
        r_mask <= st_data[KEY_W-1:0];
      end
      r_irq <= |(r_edge & r_mask);
    end
  end

  assign irq_o = r_irq;
`endif

  always_comb begin
    w_rd_data = '0;
    case (addr)
      c_addr_sw:   w_rd_data = 32'(r_sw_s2);
      c_addr_key:  w_rd_data = 32'(r_stable);
      c_addr_edge: w_rd_data = 32'(r_edge);
`ifdef INPUT_PERIPH_IRQ_EN
      c_addr_mask: w_rd_data = 32'(r_mask);
`endif
      default:     w_rd_data = '0;
    endcase
  end

  // Loads see pre-store state because the mux reads the current registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ld_data <= '0;
    end else if (ld_en) begin
      r_ld_data <= w_rd_data;
    end
  end

  assign ld_data = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_input_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_periph
// Summary  : Directed self-checking bench for input_periph (DEBOUNCE_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_periph;

  localparam int SW_W  = 18;
  localparam int KEY_W = 4;

  logic              clk_i   = 1'b0;
  logic              rst_ni  = 1'b0;
  logic [SW_W-1:0]   sw      = '0;
  logic [KEY_W-1:0]  key     = '1;
  logic              ld_en   = 1'b0;
  logic              st_en   = 1'b0;
  logic [7:0]        addr    = '0;
  logic [31:0]       st_data = '0;
  logic [31:0]       ld_data;
`ifdef INPUT_PERIPH_IRQ_EN
  logic              irq_o;
`endif

  int checks = 0;
  int errors = 0;

  input_periph #(
    .DEBOUNCE_CYCLES(16'd8),
    .SW_W           (SW_W),
    .KEY_W          (KEY_W)
  ) u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sw     (sw),
    .key    (key),
    .ld_en  (ld_en),
    .st_en  (st_en),
    .addr   (addr),
    .st_data(st_data),
    .ld_data(ld_data)
`ifdef INPUT_PERIPH_IRQ_EN
    ,
    .irq_o  (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] exp, input string tag);
    addr  = a;
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
    check(tag, ld_data, exp);
  endtask

  task automatic store(input logic [7:0] a, input logic [31:0] d);
    addr    = a;
    st_data = d;
    st_en   = 1'b1;
    tick();
    st_en   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    check("reset_ld", ld_data, 32'h0);

    sw     = 18'h2A5A5;
    rst_ni = 1'b1;
    repeat (3) tick();
    load(8'h00, 32'h0002A5A5, "sw_a5");
    sw = 18'h15A5A;
    repeat (3) tick();
    load(8'h00, 32'h00015A5A, "sw_5a");

    // 5-cycle glitch is shorter than the debounce window
    key[0] = 1'b0;
    repeat (5) tick();
    key[0] = 1'b1;
    repeat (12) tick();
    load(8'h10, 32'h0, "key_glitch");
    load(8'h20, 32'h0, "edge_glitch");

    key[0] = 1'b0;
    repeat (12) tick();
    load(8'h10, 32'h1, "key_press");
    load(8'h20, 32'h1, "edge_press");
    key[0] = 1'b1;
    repeat (14) tick();
    load(8'h10, 32'h0, "key_release");
    load(8'h20, 32'h1, "edge_after_release");

    store(8'h20, 32'h1);
    load(8'h20, 32'h0, "edge_w1c");

    key[0] = 1'b0;
    repeat (12) tick();
    key[0] = 1'b1;
    repeat (14) tick();
    load(8'h20, 32'h1, "edge_press2");
    store(8'h20, 32'h2);
    load(8'h20, 32'h1, "edge_w1c_other_bit");

    // key[1] stable flips on the 10th edge after the drive; W1C lands on that edge
    key[1] = 1'b0;
    repeat (9) tick();
    addr    = 8'h20;
    st_data = 32'h2;
    st_en   = 1'b1;
    ld_en   = 1'b1;
    tick();
    st_en   = 1'b0;
    ld_en   = 1'b0;
    check("ld_pre_set", ld_data, 32'h1);
    load(8'h20, 32'h3, "edge_set_wins");

    addr    = 8'h20;
    st_data = 32'h1;
    st_en   = 1'b1;
    ld_en   = 1'b1;
    tick();
    st_en   = 1'b0;
    ld_en   = 1'b0;
    check("ld_pre_clear", ld_data, 32'h3);
    load(8'h20, 32'h2, "edge_after_clear");

    key[1] = 1'b1;
    repeat (14) tick();
    load(8'h44, 32'h0, "unmapped_rd");
    store(8'h44, 32'hF);
    load(8'h20, 32'h2, "unmapped_st");
`ifndef INPUT_PERIPH_IRQ_EN
    store(8'h30, 32'hF);
    load(8'h30, 32'h0, "mask_unmapped");
`endif

    key = 4'h0;
    repeat (12) tick();
    load(8'h20, 32'hF, "edge_all");
    key = 4'hF;
    repeat (4) tick();
    #2 rst_ni = 1'b0;
    #1 check("async_reset_ld", ld_data, 32'h0);
    repeat (2) tick();
    rst_ni = 1'b1;
    load(8'h00, 32'h0, "sw_after_reset0");
    load(8'h00, 32'h0, "sw_after_reset1");
    load(8'h00, 32'h00015A5A, "sw_after_reset2");
    load(8'h20, 32'h0, "edge_after_reset");
    load(8'h10, 32'h0, "key_after_reset");

`ifdef INPUT_PERIPH_IRQ_EN
    check("irq_reset", 32'(irq_o), 32'h0);
    store(8'h30, 32'h4);
    load(8'h30, 32'h4, "mask_rd");
    key[2] = 1'b0;
    repeat (10) tick();
    check("irq_before", 32'(irq_o), 32'h0);
    tick();
    check("irq_set", 32'(irq_o), 32'h1);
    store(8'h20, 32'h4);
    check("irq_lag", 32'(irq_o), 32'h1);
    tick();
    check("irq_cleared", 32'(irq_o), 32'h0);
    key[0] = 1'b0;
    repeat (12) tick();
    check("irq_unmasked", 32'(irq_o), 32'h0);
    load(8'h20, 32'h1, "edge0_irq_build");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_periph.md
Name: input_periph

Overview:
- Memory-mapped input peripheral for the load path: the read-side counterpart of the output peripheral block.
- Synchronizes the board switches (sw) and push-buttons (key), debounces the keys and captures key-press edges.
- Returns register contents to the LSU on a load with one-cycle registered latency.
- Accepts stores only to clear edge-capture bits (and, when compiled in, to set the interrupt mask).

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive cycles a synchronized key level must differ from its stable value before the stable value updates (range 1..65535).
- SW_W, 18, switch count.
- KEY_W, 4, push-button count.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous reset, active low.
- sw  input  SW_W  raw slide switches, asynchronous, active high.
- key  input  KEY_W  raw push-buttons, asynchronous, active low (0 = pressed).
- ld_en  input  1  load strobe from LSU.
- st_en  input  1  store strobe from LSU.
- addr  input  8  register address.
- st_data  input  32  store data.
- ld_data  output  32  load data, registered.

Behaviour:
- Reset (rst_ni=0, asynchronous): all sync flops, stable levels, counters, edge register and ld_data cleared to 0. The key stable level resets to "not pressed" (0).
- Synchronizer: 2-FF chain per bit on sw and ~key. The synchronized value is the 2nd stage, so an input change is visible 2 cycles later.
- Switches are not debounced. sw_sync feeds the register map directly.
- Key debounce uses a 16-bit counter per key:
  - If key_sync[i] equals stable[i], the counter clears to 0.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, stable[i] takes key_sync[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - The counter saturates and never wraps.
- Edge capture: edge[i] is sticky and sets on the cycle stable[i] goes 0->1 (press). Release does not set it.
- Register map, 32-bit words, unused bits read 0:
  - 8'h00 SW: {14'b0, sw_sync}, read-only.
  - 8'h10 KEY: {28'b0, stable}, read-only; 1 means pressed.
  - 8'h20 EDGE: {28'b0, edge}. A store writes 1 to clear: edge[i] clears where st_data[i]=1.
  - Any other address: reads 0, stores ignored.
- Simultaneous set and clear of the same edge bit in one cycle: set wins, and the bit stays 1.
- Load timing: on a cycle with ld_en=1, ld_data is updated at the next posedge with the value selected by addr. When ld_en=0, ld_data holds its previous value.
- Same-cycle load and store to EDGE: ld_data returns the pre-store value. The clear is visible on the next load.
- ld_en and st_en both high is legal. Each acts independently as above.
- Reset asserted mid-debounce or mid-load: all state is immediately 0. After release, the first load returns current sync values, which are 0 for the first 2 cycles.

Optional Feature:
- Macro: INPUT_PERIPH_IRQ_EN.
- Defined:
  - Adds output port irq_o (1 bit).
  - Adds register 8'h30 MASK: {28'b0, mask}, read/write, reset 0.
  - irq_o is registered and equals |(edge & mask) one cycle after edge or mask changes. Reset value 0.
- Undefined:
  - No irq_o port and no mask flops.
  - 8'h30 behaves as an unmapped address: reads 0, stores ignored.

Test Plan:
- Reset then sw=18'h2A5A5, wait 3 cycles, load 8'h00 -> ld_data=32'h0002A5A5 the cycle after ld_en.
- DEBOUNCE_CYCLES=8: key[0]=0 held 5 cycles then back to 1 -> KEY reads 0 and EDGE reads 0. Then key[0]=0 held 12 cycles -> KEY reads 32'h1 and EDGE reads 32'h1.
- Edge set, store st_data=32'h1 to 8'h20 -> next load of 8'h20 = 0. Store 32'h2 when only bit 0 is set -> bit 0 stays set.
- New key[1] press completes debounce in the same cycle as a W1C store of 32'h2 to 8'h20 -> edge[1] remains 1.
- Load addr 8'h44 -> ld_data=0. Assert rst_ni=0 mid-debounce with edge=4'hF -> ld_data=0, EDGE reads 0 after release.
- With INPUT_PERIPH_IRQ_EN: MASK=4'h4, press key[2] -> irq_o=1 one cycle after edge[2] sets. W1C 32'h4 -> irq_o=0 next cycle. Press key[0] -> irq_o stays 0.
